// File: rtl/accum_dump_pkg.sv
// Shared types, default parameters and width helpers for accum_dump.
// Narrowing mode is selected by the ACCUM_DUMP_SAT_EN macro (see accum_dump_narrow).
package accum_dump_pkg;

  typedef enum logic [0:0] {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int DEF_IN_W  = 13;
  localparam int DEF_N     = 8;
  localparam int DEF_SHIFT = 0;
  localparam int DEF_OUT_W = 16;

  // Accumulator wide enough that N full-scale samples cannot overflow.
  function automatic int acc_width(input int in_w, input int n);
    return in_w + $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/accum_dump_narrow.sv
// Combinational post-scale of the frame sum: arithmetic shift, then saturate
// (ACCUM_DUMP_SAT_EN defined) or wrap to OUT_W bits (default).
module accum_dump_narrow #(
  parameter int ACC_W = 16,
  parameter int SHIFT = 0,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [OUT_W-1:0] data,
  output logic                    sat
);

  logic signed [ACC_W-1:0] shifted_s;

  assign shifted_s = acc >>> SHIFT;

`ifdef ACCUM_DUMP_SAT_EN
  // One guard bit above the wider of the two widths keeps the limit compares signed-safe.
  localparam int EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
  localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [EXT_W-1:0] ext_s;

  assign ext_s = EXT_W'(shifted_s);

  // Clip to the signed OUT_W range and flag it.
  always_comb begin
    data = ext_s[OUT_W-1:0];
    sat  = 1'b0;
    if (ext_s > MAX_V) begin
      data = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (ext_s < MIN_V) begin
      data = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end else begin
      data = ext_s[OUT_W-1:0];
      sat  = 1'b0;
    end
  end
`else
  assign data = OUT_W'(shifted_s);
  assign sat  = 1'b0;
`endif

endmodule

// File: rtl/accum_dump.sv
// Integrate-and-dump: sums N signed samples per frame and emits one scaled result.
// Define ACCUM_DUMP_SAT_EN for saturating narrowing; otherwise the result wraps.
module accum_dump
  import accum_dump_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int N     = DEF_N,
  parameter int SHIFT = DEF_SHIFT,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  i_data,
  input  logic                    i_valid,
  output logic                    i_ready,
  output logic signed [OUT_W-1:0] o_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic                    o_sat
);

  localparam int ACC_W = acc_width(IN_W, N);
  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if (!((N == 1) || ((N >= 2) && (N <= 256) && ((N & (N - 1)) == 0)))) begin : g_bad_n
    $error("accum_dump: N must be 1 or a power of two in 2..256");
  end

  state_e                  state_r, state_n_s;
  logic signed [ACC_W-1:0] acc_r, acc_n_s, sample_s, sum_s;
  logic [CNT_W-1:0]        cnt_r, cnt_n_s;
  logic signed [OUT_W-1:0] o_data_r, o_data_n_s, narrow_data_s;
  logic                    o_valid_r, o_valid_n_s, o_sat_r, o_sat_n_s, narrow_sat_s;
  logic                    i_ready_s, in_hs_s, out_hs_s;

  assign sample_s = ACC_W'(i_data);
  assign sum_s    = acc_r + sample_s;
  assign in_hs_s  = i_valid & i_ready_s;
  assign out_hs_s = o_valid_r & o_ready;

  accum_dump_narrow #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_narrow (
    .acc  (sum_s),
    .data (narrow_data_s),
    .sat  (narrow_sat_s)
  );

  // Input is open in ACC; in HOLD a sample may enter only alongside the output transfer.
  always_comb begin
    i_ready_s = 1'b1;
    case (state_r)
      ACC:     i_ready_s = 1'b1;
      HOLD:    i_ready_s = o_ready;
      default: i_ready_s = 1'b1;
    endcase
  end

  // Next-state logic. acc and count are already clear in HOLD, so an accept there
  // naturally starts the next frame (and with N=1 completes it at once).
  always_comb begin
    state_n_s   = state_r;
    acc_n_s     = acc_r;
    cnt_n_s     = cnt_r;
    o_data_n_s  = o_data_r;
    o_sat_n_s   = o_sat_r;
    o_valid_n_s = o_valid_r;
    if (in_hs_s) begin
      if (cnt_r == LAST_CNT) begin
        o_data_n_s  = narrow_data_s;
        o_sat_n_s   = narrow_sat_s;
        o_valid_n_s = 1'b1;
        acc_n_s     = '0;
        cnt_n_s     = '0;
        state_n_s   = HOLD;
      end else begin
        acc_n_s     = sum_s;
        cnt_n_s     = cnt_r + CNT_W'(1);
        o_valid_n_s = 1'b0;
        state_n_s   = ACC;
      end
    end else if (out_hs_s) begin
      o_valid_n_s = 1'b0;
      state_n_s   = ACC;
    end else begin
      state_n_s   = state_r;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ACC;
      acc_r     <= '0;
      cnt_r     <= '0;
      o_data_r  <= '0;
      o_sat_r   <= 1'b0;
      o_valid_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      acc_r     <= acc_n_s;
      cnt_r     <= cnt_n_s;
      o_data_r  <= o_data_n_s;
      o_sat_r   <= o_sat_n_s;
      o_valid_r <= o_valid_n_s;
    end
  end

  assign i_ready = i_ready_s;
  assign o_data  = o_data_r;
  assign o_valid = o_valid_r;
  assign o_sat   = o_sat_r;

endmodule

// File: doc/accum_dump.md
ACCUM_DUMP -- requirements
Module: accum_dump

Interface
- REQ-001 The block SHALL have parameter IN_W, default 13, meaning signed two's-complement input width (the adder-stage result width).
- REQ-002 The block SHALL have parameter N, default 8, meaning samples per frame (power of two, 2..256).
- REQ-003 The block SHALL have parameter SHIFT, default 0, meaning arithmetic right shift applied to the frame sum.
- REQ-004 The block SHALL have parameter OUT_W, default 16, meaning signed output width.
- REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic rises on its positive edge.
- REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
- REQ-007 The block SHALL have port i_data, input, IN_W bits: the signed sample from the upstream adder stage.
- REQ-008 The block SHALL have port i_valid, input, 1 bit: i_data is valid.
- REQ-009 The block SHALL have port i_ready, output, 1 bit: the block accepts a sample this cycle.
- REQ-010 The block SHALL have port o_data, output, OUT_W bits: the signed frame result.
- REQ-011 The block SHALL have port o_valid, output, 1 bit: o_data is valid.
- REQ-012 The block SHALL have port o_ready, input, 1 bit: downstream accepts o_data.
- REQ-013 The block SHALL have port o_sat, output, 1 bit: the current o_data was clipped.

Function
- REQ-014 The block SHALL accept a sample only on cycles where i_valid and i_ready are both 1; o_data is transferred only when o_valid and o_ready are both 1.
- REQ-015 The block SHALL implement two states, ACC and HOLD; reset enters ACC.
- REQ-016 In ACC, i_ready SHALL be 1; each accepted sample is sign-extended and added to the accumulator, and the sample counter increments.
- REQ-017 On the Nth accepted sample, the block SHALL register result = narrow((acc + sample) >>> SHIFT); o_valid rises the next cycle, the accumulator and counter clear, and the state moves to HOLD.
- REQ-018 The accumulator width SHALL be ACC_W = IN_W + clog2(N), so internal overflow cannot occur.
- REQ-019 In HOLD, o_data, o_sat and o_valid SHALL remain stable until the output handshake, and i_ready SHALL equal o_ready.
- REQ-020 If the output handshake and an input handshake occur in the same HOLD cycle, the block SHALL return to ACC with that sample counted as sample 1 of the new frame (no bubble).
- REQ-021 If the output handshake occurs without an input handshake, the block SHALL clear o_valid next cycle and return to ACC with count 0.
- REQ-022 The block SHALL ignore i_data whenever i_ready is 0.
- REQ-023 With N=1, every accepted sample SHALL produce one output.

Reset
- REQ-024 On rst=1 at a clock edge, the block SHALL set state=ACC, counter=0, acc=0, o_valid=0, o_data=0 and o_sat=0; i_ready is 1 in the first cycle after reset.
- REQ-025 A reset mid-frame or in HOLD SHALL discard the partial sum or the pending output; no output is produced for the discarded frame.

Configuration
- REQ-026 The block SHALL use macro ACCUM_DUMP_SAT_EN to select the narrowing behaviour.
- REQ-027 With ACCUM_DUMP_SAT_EN defined, narrow() SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set o_sat=1 when clipping occurs.
- REQ-028 Without ACCUM_DUMP_SAT_EN, narrow() SHALL keep the low OUT_W bits (wrap) and tie o_sat to 0.

Structure
- REQ-029 Package accum_dump_pkg SHALL hold the state enum (ACC, HOLD), the default parameter constants and an ACC_W width function.
- REQ-030 One sub-module, accum_dump_narrow (combinational shift plus saturate/wrap), SHALL be instantiated once.
- REQ-031 An elaboration check SHALL reject a non-power-of-two N and any N outside 2..256 other than N=1.

Verification
- REQ-032 Scenario: defaults, eight samples of 100 with o_ready=1 -> o_data=800, o_valid for 1 cycle, starting the cycle after the 8th accept.
- REQ-033 Scenario: OUT_W=12, eight samples of 1000 -> with SAT_EN, o_data=2047 and o_sat=1; without SAT_EN, o_data=-192 and o_sat=0.
- REQ-034 Scenario: o_ready held 0 for 5 cycles after o_valid -> o_data stable and i_ready=0; then o_ready=1 with i_valid=1 and i_data=7 -> output accepted, and the next frame of 7 plus seven samples of 1 gives 14.
- REQ-035 Scenario: rst pulsed after 5 samples of 50, then eight samples of 2 -> o_data=16.
- REQ-036 Scenario: SHIFT=3, eight samples of -1 -> o_data=-1; eight samples of 4095 -> o_data=4095.
